// File: rtl/derived_clock_div.sv
// derived_clock_div: counts selected edges of a slow clk_in in the clk domain
// and toggles output_clk every N+1 counted edges.
//
// Configuration macro: DCLK_SYNC_EN
//   defined   : clk_in passes through a SYNC_STAGES-deep synchroniser (reset to 0)
//   undefined : clk_in is used directly and must be synchronous to clk
//
// Ports:
//   clk        in   1      system clock, posedge
//   rst_n      in   1      asynchronous active-low reset
//   clk_in     in   1      signal whose edges are counted
//   N          in   CNT_W  half-period in counted edges minus one, sampled live
//   mode       in   2      00 none, 01 rising, 10 falling, 11 both
//   enable     in   1      1 = count edges, 0 = hold
//   clear      in   1      synchronous clear of count, output_clk and tick
//   output_clk out  1      divided clock, registered
//   tick       out  1      one-cycle pulse in the cycle output_clk changes
//   count      out  CNT_W  current edge count
module derived_clock_div #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic [CNT_W-1:0] N,
    input  logic [1:0]       mode,
    input  logic             enable,
    input  logic             clear,
    output logic             output_clk,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    // Reject an illegal synchroniser depth at elaboration.
    if (SYNC_STAGES < 2) begin : g_stages_chk
        $error("derived_clock_div: SYNC_STAGES must be >= 2");
    end

    logic s;

`ifdef DCLK_SYNC_EN
    // Synchroniser chain; s is the last stage.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    assign s = clk_in;
`endif

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             rise, fall, sel;

    // Edge detection; prev tracks s regardless of enable so re-enabling makes no false edge.
    always_comb begin
        rise = s & ~prev_q;
        fall = ~s & prev_q;
        sel  = (mode[0] & rise) | (mode[1] & fall);
    end

    // Next state: clear beats counting beats hold.
    always_comb begin
        prev_d  = s;
        count_d = count_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
            out_d   = 1'b0;
        end else if (enable && sel) begin
            // >= so that lowering N below the current count wraps on the next edge.
            if (count_q >= N) begin
                count_d = '0;
                out_d   = ~out_q;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            count_q <= '0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign output_clk = out_q;
    assign tick       = tick_q;
    assign count      = count_q;

endmodule
